// File: rtl/battle_pkg.sv
// Shared definitions for the battle controller and its datapath bench:
// state encoding, control-output bundle and the default result-hold length.
package battle_pkg;

    localparam int HOLD_CYCLES_DEF = 8;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_MOVE = 4'd1,
        S_PL_FREEZE = 4'd2,
        S_PL_APPLY  = 4'd3,
        S_PL_CHECK  = 4'd4,
        S_AI_FREEZE = 4'd5,
        S_AI_APPLY  = 4'd6,
        S_AI_CHECK  = 4'd7,
        S_WIN       = 4'd8,
        S_LOSE      = 4'd9
    } state_t;

    typedef struct packed {
        logic stop;
        logic actr;
        logic target;
        logic load_ai_hp;
        logic app_ai_dmg;
        logic app_pl_dmg;
        logic win;
        logic lose;
    } ctrl_t;

    // Moore decode; registered by the controller against the next state so
    // outputs line up with the state register.
    function automatic ctrl_t decode_state(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_PL_FREEZE: begin c.stop = 1'b1; c.target = 1'b1; c.load_ai_hp = 1'b1; end
            S_PL_APPLY:  begin c.stop = 1'b1; c.target = 1'b1; c.app_ai_dmg = 1'b1; end
            S_PL_CHECK:  begin c.stop = 1'b1; c.target = 1'b1; end
            S_AI_FREEZE: begin c.stop = 1'b1; c.actr = 1'b1; end
            S_AI_APPLY:  begin c.stop = 1'b1; c.actr = 1'b1; c.app_pl_dmg = 1'b1; end
            S_AI_CHECK:  begin c.stop = 1'b1; c.actr = 1'b1; end
            S_WIN:       c.win  = 1'b1;
            S_LOSE:      c.lose = 1'b1;
            default:     c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer for the raw confirm button plus a rising-edge
// detector; a held button yields a single one-cycle pulse.
module btn_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_pulse
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_pulse = r_s2 & ~r_s3;

endmodule

// File: rtl/battle_ctrl.sv
// Turn sequencer for the battle game: player strike, AI strike, result
// hold, with all datapath controls registered from the next state.
//
// state       | meaning
// IDLE        | waiting for go to start a game
// WAIT_MOVE   | waiting for go to latch the player's move
// PL_FREEZE   | RNGs frozen, AI HP snapshot
// PL_APPLY    | player damage applied to AI
// PL_CHECK    | AI defeated -> WIN
// AI_FREEZE   | AI attacks, RNGs frozen
// AI_APPLY    | AI damage applied to player
// AI_CHECK    | player defeated -> LOSE, else turn complete
// WIN / LOSE  | result held, go honoured after the hold time
module battle_ctrl
    import battle_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [1:0] p_move_in,
    input  logic       ai_dead,
    input  logic [3:0] p_hp,
    output logic [1:0] p_move,
    output logic       actr,
    output logic       target,
    output logic       stop,
    output logic       load_ai_hp,
    output logic       app_ai_dmg,
    output logic       app_pl_dmg,
    output logic [3:0] turn_cnt,
    output logic       win,
    output logic       lose
);

    localparam logic [3:0] HOLD_LIM  = 4'(HOLD_CYCLES);
    localparam logic [3:0] TURN_MAX  = 4'd15;

    state_t      r_state;
    state_t      w_next;
    ctrl_t       r_ctrl;
    logic [1:0]  r_p_move;
    logic [3:0]  r_turn;
    logic [3:0]  r_hold;
    logic        w_go_pulse;
    logic        w_in_result;
    logic        w_hold_done;

    btn_sync u_btn_sync (
        .clk     (clk),
        .rst_n   (rst),
        .i_btn   (go),
        .o_pulse (w_go_pulse)
    );

    assign w_in_result = (r_state == S_WIN) || (r_state == S_LOSE);
    assign w_hold_done = (r_hold >= HOLD_LIM);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_go_pulse) w_next = S_WAIT_MOVE;
            S_WAIT_MOVE: if (w_go_pulse) w_next = S_PL_FREEZE;
            S_PL_FREEZE: w_next = S_PL_APPLY;
            S_PL_APPLY:  w_next = S_PL_CHECK;
            S_PL_CHECK:  w_next = ai_dead ? S_WIN : S_AI_FREEZE;
            S_AI_FREEZE: w_next = S_AI_APPLY;
            S_AI_APPLY:  w_next = S_AI_CHECK;
            S_AI_CHECK:  w_next = (p_hp == 4'd0) ? S_LOSE : S_WAIT_MOVE;
            S_WIN,
            S_LOSE:      if (w_go_pulse && w_hold_done) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ctrl   <= '0;
            r_p_move <= 2'd0;
            r_turn   <= 4'd0;
            r_hold   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_ctrl  <= decode_state(w_next);

            if (r_state == S_WAIT_MOVE && w_go_pulse)
                r_p_move <= p_move_in;

            if (r_state == S_AI_CHECK && p_hp != 4'd0 && r_turn != TURN_MAX)
                r_turn <= r_turn + 4'd1;
            else if (w_in_result && w_next == S_IDLE)
                r_turn <= 4'd0;

            // Hold counter sits at zero outside the result states, so it is
            // already clear on entry and saturates at the hold limit.
            if (!w_in_result)
                r_hold <= 4'd0;
            else if (!w_hold_done)
                r_hold <= r_hold + 4'd1;
        end
    end

    assign p_move     = r_p_move;
    assign turn_cnt   = r_turn;
    assign stop       = r_ctrl.stop;
    assign actr       = r_ctrl.actr;
    assign target     = r_ctrl.target;
    assign load_ai_hp = r_ctrl.load_ai_hp;
    assign app_ai_dmg = r_ctrl.app_ai_dmg;
    assign app_pl_dmg = r_ctrl.app_pl_dmg;
    assign win        = r_ctrl.win;
    assign lose       = r_ctrl.lose;

endmodule

// File: tb/tb_battle_ctrl.sv
// Scoreboard bench for battle_ctrl: stimulus queues expected output vectors,
// a monitor pops one each time the DUT's output vector changes.
module tb_battle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       go = 1'b0;
    logic [1:0] p_move_in = 2'b00;
    logic       ai_dead = 1'b0;
    logic [3:0] p_hp = 4'd5;
    logic [1:0] p_move;
    logic       actr, target, stop, load_ai_hp, app_ai_dmg, app_pl_dmg, win, lose;
    logic [3:0] turn_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [13:0] v;
        int          dt;
    } exp_t;
    exp_t q[$];

    // {stop, actr, target, load_ai_hp, app_ai_dmg, app_pl_dmg, win, lose}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_PLF  = 8'b1011_0000;
    localparam logic [7:0] C_PLA  = 8'b1010_1000;
    localparam logic [7:0] C_PLC  = 8'b1010_0000;
    localparam logic [7:0] C_AIF  = 8'b1100_0000;
    localparam logic [7:0] C_AIA  = 8'b1100_0100;
    localparam logic [7:0] C_AIC  = 8'b1100_0000;
    localparam logic [7:0] C_WIN  = 8'b0000_0010;
    localparam logic [7:0] C_LOSE = 8'b0000_0001;

    logic [13:0] w_vec;
    assign w_vec = {p_move, turn_cnt, stop, actr, target, load_ai_hp,
                    app_ai_dmg, app_pl_dmg, win, lose};

    battle_ctrl #(.HOLD_CYCLES(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .go         (go),
        .p_move_in  (p_move_in),
        .ai_dead    (ai_dead),
        .p_hp       (p_hp),
        .p_move     (p_move),
        .actr       (actr),
        .target     (target),
        .stop       (stop),
        .load_ai_hp (load_ai_hp),
        .app_ai_dmg (app_ai_dmg),
        .app_pl_dmg (app_pl_dmg),
        .turn_cnt   (turn_cnt),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] mk(input logic [1:0] pm, input logic [3:0] tc,
                                       input logic [7:0] c);
        return {pm, tc, c};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [13:0] v, input int dt);
        exp_t e;
        e.v  = v;
        e.dt = dt;
        q.push_back(e);
    endtask

    // Full turn: player strike then AI strike, back to WAIT_MOVE.
    task automatic push_turn(input logic [1:0] pm, input logic [3:0] t0);
        logic [3:0] t1;
        t1 = (t0 == 4'd15) ? 4'd15 : t0 + 4'd1;
        push(mk(pm, t0, C_PLF), -1);
        push(mk(pm, t0, C_PLA), 1);
        push(mk(pm, t0, C_PLC), 1);
        push(mk(pm, t0, C_AIF), 1);
        push(mk(pm, t0, C_AIA), 1);
        push(mk(pm, t0, C_AIC), 1);
        push(mk(pm, t1, C_NONE), 1);
    endtask

    task automatic pulse_go(input int hi);
        @(negedge clk) go = 1'b1;
        repeat (hi) @(negedge clk);
        go = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic do_turn(input logic [1:0] pm, input logic [3:0] t0);
        p_move_in = pm;
        push_turn(pm, t0);
        pulse_go(1);
        repeat (8) @(negedge clk);
    endtask

    // Monitor: one scoreboard pop per change of the output vector.
    initial begin
        logic [13:0] prev;
        int          cyc;
        int          last;
        exp_t        e;
        prev = '0;
        cyc  = 0;
        last = 0;
        @(posedge rst);
        forever begin
            @(negedge clk);
            cyc++;
            chk("excl_dmg", {31'd0, app_ai_dmg & app_pl_dmg}, 32'd0);
            chk("excl_result", {31'd0, win & lose}, 32'd0);
            if (w_vec !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event actual=%h dt=%0d required=none", w_vec, cyc - last);
                end else begin
                    e = q.pop_front();
                    if (w_vec !== e.v || (e.dt >= 0 && (cyc - last) != e.dt)) begin
                        errors++;
                        $display("FAIL event actual=%h dt=%0d required=%h dt=%0d",
                                 w_vec, cyc - last, e.v, e.dt);
                    end
                end
                prev = w_vec;
                last = cyc;
            end
        end
    end

    initial begin
        logic [3:0] t;
        logic [1:0] pm;

        #3;
        chk("reset_outputs", {18'd0, w_vec}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // IDLE -> WAIT_MOVE, then first turn with move 2'b10
        pulse_go(1);
        do_turn(2'b10, 4'd0);
        chk("p_move_latched", {30'd0, p_move}, 32'd2);
        chk("turn_one", {28'd0, turn_cnt}, 32'd1);

        // AI defeated at PL_CHECK: straight to WIN, no AI strike
        ai_dead   = 1'b1;
        p_move_in = 2'b01;
        push(mk(2'b01, 4'd1, C_PLF), -1);
        push(mk(2'b01, 4'd1, C_PLA), 1);
        push(mk(2'b01, 4'd1, C_PLC), 1);
        push(mk(2'b01, 4'd1, C_WIN), 1);
        pulse_go(1);
        repeat (14) @(negedge clk);
        ai_dead = 1'b0;
        push(mk(2'b01, 4'd0, C_NONE), -1);
        pulse_go(1);
        repeat (4) @(negedge clk);

        // Player defeated at AI_CHECK; early go ignored, late go honoured
        pulse_go(1);
        p_hp      = 4'd0;
        p_move_in = 2'b11;
        push(mk(2'b11, 4'd0, C_PLF), -1);
        push(mk(2'b11, 4'd0, C_PLA), 1);
        push(mk(2'b11, 4'd0, C_PLC), 1);
        push(mk(2'b11, 4'd0, C_AIF), 1);
        push(mk(2'b11, 4'd0, C_AIA), 1);
        push(mk(2'b11, 4'd0, C_AIC), 1);
        push(mk(2'b11, 4'd0, C_LOSE), 1);
        push(mk(2'b11, 4'd0, C_NONE), 13);
        pulse_go(1);
        for (int k = 0; k < 40 && !lose; k++) @(negedge clk);
        chk("lose_seen", {31'd0, lose}, 32'd1);
        @(negedge clk) go = 1'b1;      // sampled at hold count 3
        repeat (2) @(negedge clk);
        go = 1'b0;
        repeat (7) @(negedge clk);
        go = 1'b1;                     // sampled with hold saturated
        repeat (2) @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        p_hp = 4'd5;

        // go held for 50 cycles in WAIT_MOVE: exactly one latch and one turn
        pulse_go(1);
        p_move_in = 2'b00;
        push_turn(2'b00, 4'd0);
        @(negedge clk) go = 1'b1;
        repeat (20) @(negedge clk);
        p_move_in = 2'b11;
        repeat (30) @(negedge clk);
        go = 1'b0;
        repeat (5) @(negedge clk);
        chk("held_go_p_move", {30'd0, p_move}, 32'd0);

        // 16 more turns: turn count saturates at 15
        t = 4'd1;
        for (int i = 0; i < 16; i++) begin
            pm = 2'(i);
            do_turn(pm, t);
            t = (t == 4'd15) ? 4'd15 : t + 4'd1;
        end
        chk("turn_saturated", {28'd0, turn_cnt}, 32'd15);

        // Reset during AI_FREEZE aborts the turn
        p_move_in = 2'b01;
        push(mk(2'b01, 4'd15, C_PLF), -1);
        push(mk(2'b01, 4'd15, C_PLA), 1);
        push(mk(2'b01, 4'd15, C_PLC), 1);
        push(mk(2'b01, 4'd15, C_AIF), 1);
        push(mk(2'b00, 4'd0, C_NONE), 1);
        @(negedge clk) go = 1'b1;
        @(negedge clk) go = 1'b0;
        for (int k = 0; k < 20 && !actr; k++) @(negedge clk);
        chk("ai_freeze_seen", {31'd0, actr}, 32'd1);
        #1 rst = 1'b0;
        #1 chk("mid_turn_reset", {18'd0, w_vec}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("no_pl_dmg_in_reset", {31'd0, app_pl_dmg}, 32'd0);
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < 100 && q.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/battle_ctrl.md
BATTLE_CTRL -- requirements
Module: battle_ctrl

Interface
REQ-001 The block SHALL have one clock and use an asynchronous, active-low reset.
REQ-002 Parameter: HOLD_CYCLES, default 8, minimum number of cycles WIN/LOSE is held before go is honoured.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 go  input  1  raw player confirm button, asynchronous to clk.
REQ-006 p_move_in  input  2  player move selection from switches.
REQ-007 ai_dead  input  1  datapath flag, AI HP == 0.
REQ-008 p_hp  input  4  datapath player HP; zero means player defeated.
REQ-009 p_move  output  2  latched player move to datapath.
REQ-010 actr  output  1  attacker select: 0 player, 1 AI.
REQ-011 target  output  1  damage target: 0 player, 1 AI.
REQ-012 stop  output  1  freezes datapath RNGs while high.
REQ-013 load_ai_hp  output  1  one-cycle snapshot strobe.
REQ-014 app_ai_dmg / app_pl_dmg  output  1 each  one-cycle damage-apply strobes.
REQ-015 turn_cnt  output  4  completed full turns.
REQ-016 win / lose  output  1 each  game result flags.

Function
REQ-017 go SHALL pass a 2-flop synchronizer plus rising-edge detector, producing go_pulse, one cycle wide, high on the 3rd rising edge after go rises; a held go SHALL give exactly one pulse.
REQ-018 States: IDLE, WAIT_MOVE, PL_FREEZE, PL_APPLY, PL_CHECK, AI_FREEZE, AI_APPLY, AI_CHECK, WIN, LOSE; encoded in one state register.
REQ-019 IDLE: all strobes 0, stop 0; go_pulse -> WAIT_MOVE.
REQ-020 WAIT_MOVE: stop 0; on go_pulse p_move <= p_move_in in the same edge, -> PL_FREEZE.
REQ-021 PL_FREEZE (1 cycle): stop 1, actr 0, target 1, load_ai_hp 1 -> PL_APPLY.
REQ-022 PL_APPLY (1 cycle): stop 1, actr 0, target 1, app_ai_dmg 1 -> PL_CHECK.
REQ-023 PL_CHECK (1 cycle): stop 1, actr 0, target 1; ai_dead 1 -> WIN, else -> AI_FREEZE.
REQ-024 AI_FREEZE (1 cycle): stop 1, actr 1, target 0 -> AI_APPLY.
REQ-025 AI_APPLY (1 cycle): stop 1, actr 1, target 0, app_pl_dmg 1 -> AI_CHECK.
REQ-026 AI_CHECK (1 cycle): stop 1, actr 1, target 0; p_hp == 0 -> LOSE, else turn_cnt increments and the state -> WAIT_MOVE.
REQ-027 turn_cnt SHALL saturate at 15, never wrap.
REQ-028 WIN/LOSE: win or lose held 1, stop 0; a 4-bit hold counter clears on entry and counts to HOLD_CYCLES; go_pulse before it reaches HOLD_CYCLES is ignored; go_pulse after that -> IDLE, turn_cnt <= 0, win/lose <= 0.
REQ-029 All outputs SHALL be registered Moore decodes of state; the latency from go_pulse to the first app_ai_dmg is exactly 2 cycles.
REQ-030 go_pulse in any state other than IDLE, WAIT_MOVE, WIN or LOSE SHALL be dropped, not queued.
REQ-031 app_ai_dmg and app_pl_dmg SHALL never be high in the same cycle; win and lose SHALL never both be high.
REQ-032 ai_dead and p_hp SHALL be sampled only in their CHECK states; their values elsewhere have no effect.

Reset
REQ-033 On rst low, asynchronously: state IDLE, p_move 0, turn_cnt 0, all strobes, actr, target, stop, win, lose 0, synchronizer and hold counter 0.
REQ-034 Reset asserted mid-turn SHALL abort the turn with no strobe emitted after assertion.

Structure
REQ-035 Shared package battle_pkg SHALL hold the state enum and the HOLD_CYCLES default, shared with the datapath bench.
REQ-036 Sub-module btn_sync SHALL implement the synchronizer and edge detector.

Verification
REQ-037 Reset, go pulsed, p_move_in = 2'b10, go pulsed again -> p_move = 2'b10; the sequence PL_FREEZE, PL_APPLY, PL_CHECK, AI_FREEZE, AI_APPLY, AI_CHECK occurs 1 cycle each; turn_cnt = 1.
REQ-038 ai_dead = 1 at PL_CHECK -> win = 1 next cycle; no app_pl_dmg; turn_cnt unchanged.
REQ-039 p_hp = 0 at AI_CHECK -> lose = 1; go pulsed at hold count 3 ignored; go after 8 cycles -> IDLE, turn_cnt 0.
REQ-040 go held high 50 cycles in WAIT_MOVE -> exactly one p_move latch; 16 full turns -> turn_cnt stays 15.
REQ-041 rst low during AI_FREEZE -> all outputs 0 immediately; no app_pl_dmg after the rst edge.
